// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: computes a - b - bin one DIGIT-bit slice per clock,
// LSB slice first, and presents diff/bout/ovf with a one-cycle done pulse.
module serial_subtractor #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   generate
      if (!(WIDTH >= 1 && DIGIT >= 1 && (WIDTH % DIGIT) == 0)) begin : g_bad_params
         $error("serial_subtractor: WIDTH must be >= 1 and a multiple of DIGIT >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh;   // a_sh fills with result slices as a is consumed
   logic [WIDTH-1:0] a_nxt, b_nxt;
   logic             br;
   logic [CW-1:0]    cnt;
   logic             a_msb, b_msb;
   logic [DIGIT-1:0] slice_d;
   logic             slice_br;
   logic             last;

   assign last = (cnt == CW'(N - 1));

   // Full-subtractor ripple across one slice.
   always_comb begin
      // NOTE: blocking assignments here let br_c carry from stage k into stage k+1
      // within the same evaluation; non-blocking would read a stale borrow.
      logic br_c;
      slice_d = '0;
      br_c    = br;
      for (int k = 0; k < DIGIT; k++) begin
         slice_d[k] = a_sh[k] ^ b_sh[k] ^ br_c;
         br_c       = (~a_sh[k] & b_sh[k]) | (~(a_sh[k] ^ b_sh[k]) & br_c);
      end
      slice_br = br_c;
   end

   generate
      if (N == 1) begin : g_single
         assign a_nxt = slice_d;
         assign b_nxt = b_sh;
      end else begin : g_multi
         assign a_nxt = {slice_d, a_sh[WIDTH-1:DIGIT]};
         assign b_nxt = {b_sh[DIGIT-1:0], b_sh[WIDTH-1:DIGIT]};
      end
   endgenerate

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: the datapath registers are reset along with the FSM because the
   // result outputs are required to read zero during reset, not just the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         diff  <= '0;
         bout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (start) begin
               a_sh  <= a;
               b_sh  <= b;
               br    <= bin;
               cnt   <= '0;
               a_msb <= a[WIDTH-1];
               b_msb <= b[WIDTH-1];
            end
            RUN: begin
               a_sh <= a_nxt;
               b_sh <= b_nxt;
               br   <= slice_br;
               cnt  <= cnt + CW'(1);
               if (last) begin
                  diff <= a_nxt;
                  bout <= slice_br;
                  ovf  <= (a_msb ^ b_msb) & (a_msb ^ a_nxt[WIDTH-1]);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: three instances (8/1, 8/4, 1/1) driven
// with directed vectors; per-instance monitors pop expected results on done.
module tb_serial_subtractor;

   typedef struct {
      logic [7:0] diff;
      logic       bout;
      logic       ovf;
      int         e0;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   int         cyc = 0;
   int         n_vec = 0;
   int         n_miss = 0;

   logic       s8 = 0, bin8 = 0, busy8, done8, bo8, ov8;
   logic [7:0] a8 = 0, b8 = 0, d8;
   logic       s4 = 0, bin4 = 0, busy4, done4, bo4, ov4;
   logic [7:0] a4 = 0, b4 = 0, d4;
   logic       s1 = 0, bin1 = 0, busy1, done1, bo1, ov1;
   logic       a1 = 0, b1 = 0, d1;

   int         bc8 = 0, bc4 = 0, bc1 = 0;
   exp_t       q8[$], q4[$], q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut8 (
      .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff(d8), .bout(bo8), .ovf(ov8));
   serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut4 (
      .clk(clk), .rst(rst), .start(s4), .a(a4), .b(b4), .bin(bin4),
      .busy(busy4), .done(done4), .diff(d4), .bout(bo4), .ovf(ov4));
   serial_subtractor #(.WIDTH(1), .DIGIT(1)) dut1 (
      .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1), .bin(bin1),
      .busy(busy1), .done(done1), .diff(d1), .bout(bo1), .ovf(ov1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int qsize(input int w);
      case (w)
         8:       return q8.size();
         4:       return q4.size();
         default: return q1.size();
      endcase
   endfunction

   // Monitor side: pop the oldest expected result and compare, including latency.
   task automatic score(input int w, input logic [7:0] d, input logic bo, input logic ov,
                        input int n, input int bc);
      exp_t e;
      if (qsize(w) == 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL unexpected_done w%0d: done seen with no pending operation (cycle %0d)", w, cyc);
         return;
      end
      case (w)
         8:       e = q8.pop_front();
         4:       e = q4.pop_front();
         default: e = q1.pop_front();
      endcase
      check($sformatf("diff_w%0d", w), 32'(d), 32'(e.diff));
      check($sformatf("bout_w%0d", w), 32'(bo), 32'(e.bout));
      check($sformatf("ovf_w%0d", w), 32'(ov), 32'(e.ovf));
      check($sformatf("latency_w%0d", w), 32'(cyc - e.e0), 32'(n));
      check($sformatf("busy_cycles_w%0d", w), 32'(bc), 32'(n));
   endtask

   always @(negedge clk) begin
      bc8 <= (rst || done8) ? 0 : bc8 + int'(busy8);
      if (!rst && done8) score(8, d8, bo8, ov8, 8, bc8);
   end
   always @(negedge clk) begin
      bc4 <= (rst || done4) ? 0 : bc4 + int'(busy4);
      if (!rst && done4) score(4, d4, bo4, ov4, 2, bc4);
   end
   always @(negedge clk) begin
      bc1 <= (rst || done1) ? 0 : bc1 + int'(busy1);
      if (!rst && done1) score(1, {7'b0, d1}, bo1, ov1, 1, bc1);
   end

   // Stimulus side: issue a start, then push the hand-computed expectation.
   task automatic op(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] ed, input logic eb, input logic eo);
      exp_t e;
      @(negedge clk);
      case (w)
         8:       begin a8 = a; b8 = b; bin8 = bin; s8 = 1'b1; end
         4:       begin a4 = a; b4 = b; bin4 = bin; s4 = 1'b1; end
         default: begin a1 = a[0]; b1 = b[0]; bin1 = bin; s1 = 1'b1; end
      endcase
      @(posedge clk);
      #1;
      e.diff = ed;
      e.bout = eb;
      e.ovf  = eo;
      e.e0   = cyc;
      case (w)
         8:       begin q8.push_back(e); s8 = 1'b0; check("busy_after_start_w8", 32'(busy8), 1); end
         4:       begin q4.push_back(e); s4 = 1'b0; check("busy_after_start_w4", 32'(busy4), 1); end
         default: begin q1.push_back(e); s1 = 1'b0; check("busy_after_start_w1", 32'(busy1), 1); end
      endcase
   endtask

   task automatic wait_done(input int w);
      for (int i = 0; i < 40 && qsize(w) != 0; i++) @(negedge clk);
      if (qsize(w) != 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL timeout_w%0d: no done within 40 cycles (cycle %0d)", w, cyc);
         case (w)
            8:       q8.delete();
            4:       q4.delete();
            default: q1.delete();
         endcase
      end
   endtask

   task automatic run(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin,
                      input logic [7:0] ed, input logic eb, input logic eo);
      op(w, a, b, bin, ed, eb, eo);
      wait_done(w);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      #2;
      check("reset_busy8", 32'(busy8), 0);
      check("reset_done8", 32'(done8), 0);
      check("reset_diff8", 32'(d8), 0);
      check("reset_flags8", 32'({bo8, ov8}), 0);
      check("reset_idle_w4_w1", 32'({busy4, done4, busy1, done1}), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // WIDTH=8, DIGIT=1
      run(8, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
      run(8, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
      run(8, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);

      // Starts with other operands during RUN must be ignored; old result held.
      op(8, 8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1; s8 = 1'b1;
         check("hold_diff_in_run", 32'(d8), 32'h7F);
         check("hold_ovf_in_run", 32'(ov8), 1);
      end
      @(negedge clk);
      s8 = 1'b0;
      wait_done(8);

      run(8, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
      run(8, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

      // Reset at slice 4: outputs clear at once, no done, then normal operation.
      op(8, 8'h12, 8'h34, 1'b0, 8'hDE, 1'b1, 1'b0);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrun_reset_busy", 32'(busy8), 0);
      check("midrun_reset_done", 32'(done8), 0);
      check("midrun_reset_diff", 32'(d8), 0);
      check("midrun_reset_flags", 32'({bo8, ov8}), 0);
      q8.delete();
      s8 = 1'b1;
      a8 = 8'h55;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      s8  = 1'b0;
      @(posedge clk);
      #1 check("idle_after_reset", 32'(busy8), 0);
      repeat (12) @(negedge clk);
      run(8, 8'h12, 8'h34, 1'b0, 8'hDE, 1'b1, 1'b0);

      // WIDTH=8, DIGIT=4
      run(4, 8'h3C, 8'h3C, 1'b1, 8'hFF, 1'b1, 1'b0);
      run(4, 8'h12, 8'h34, 1'b0, 8'hDE, 1'b1, 1'b0);
      run(4, 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1);

      // WIDTH=1, DIGIT=1: full-subtractor truth table (a, b, bin) -> diff/bout/ovf
      run(1, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
      run(1, 8'd0, 8'd0, 1'b1, 8'd1, 1'b1, 1'b0);
      run(1, 8'd0, 8'd1, 1'b0, 8'd1, 1'b1, 1'b1);
      run(1, 8'd0, 8'd1, 1'b1, 8'd0, 1'b1, 1'b0);
      run(1, 8'd1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0);
      run(1, 8'd1, 8'd0, 1'b1, 8'd0, 1'b0, 1'b1);
      run(1, 8'd1, 8'd1, 1'b0, 8'd0, 1'b0, 1'b0);
      run(1, 8'd1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b0);

      repeat (5) @(negedge clk);
      check("pending_results", 32'(q8.size() + q4.size() + q1.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 1, giving the bits subtracted per clock cycle.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a subtraction.
REQ-006 The block SHALL have port a, input, WIDTH bits: minuend.
REQ-007 The block SHALL have port b, input, WIDTH bits: subtrahend.
REQ-008 The block SHALL have port bin, input, 1 bit: borrow-in.
REQ-009 The block SHALL have port busy, output, 1 bit: a subtraction is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a new valid result.
REQ-011 The block SHALL have port diff, output, WIDTH bits: a - b - bin, modulo 2^WIDTH.
REQ-012 The block SHALL have port bout, output, 1 bit: borrow-out of the MSB.
REQ-013 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-014 Elaboration SHALL fail unless WIDTH>=1, DIGIT>=1 and WIDTH%DIGIT==0; N = WIDTH/DIGIT.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 In IDLE with start=1 at edge E0, the block SHALL latch a, b and bin, enter RUN, and assert busy=1 from E0.
REQ-017 start SHALL be ignored in RUN and DONE; a, b and bin SHALL be sampled only at E0.
REQ-018 In RUN, slice i (bits i*DIGIT..i*DIGIT+DIGIT-1, LSB slice first) SHALL be computed through a DIGIT-stage full-subtractor ripple and registered at edge E(i+1).
REQ-019 Each ripple stage SHALL compute d = x^y^br and br_next = (~x&y) | (~(x^y)&br); the slice-0 borrow-in SHALL be bin, and each later slice SHALL use the prior slice's registered borrow.
REQ-020 At edge EN, the block SHALL update diff, bout and ovf together, move the FSM to DONE, drive busy=0, and drive done=1 for exactly one cycle.
REQ-021 ovf SHALL equal (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB]), using the latched operands.
REQ-022 DONE SHALL return to IDLE unconditionally at the next edge; a new start is accepted one cycle after done.
REQ-023 Latency SHALL be fixed: done is high in the cycle following EN, N edges after E0, independent of data.
REQ-024 diff, bout and ovf SHALL hold their previous values throughout RUN and IDLE until the next EN.
REQ-025 With N=1 (DIGIT=WIDTH), the block SHALL still pass through RUN for one cycle, giving latency 1.

Reset
REQ-026 While rst=1, the block SHALL immediately force state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, and clear the slice counter and internal borrow.
REQ-027 If rst is asserted mid-RUN, the operation SHALL be abandoned, no done pulse SHALL occur, and after release the block SHALL be idle and accept start.
REQ-028 start SHALL be ignored while rst=1.

Verification
REQ-029 WIDTH=8, DIGIT=1, a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0, ovf=0; done 8 edges after start; busy high for 8 cycles.
REQ-030 WIDTH=8, DIGIT=1, a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0; then a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1.
REQ-031 WIDTH=8, DIGIT=4, a=0x3C, b=0x3C, bin=1 -> diff=0xFF, bout=1, ovf=0; done 2 edges after start.
REQ-032 WIDTH=1, DIGIT=1, all 8 {a, b, bin} combinations -> diff/bout match the full-subtractor truth table: (0,0,0)->0/0, (0,0,1)->1/1, (0,1,0)->1/1, (0,1,1)->0/1, (1,0,0)->1/0, (1,0,1)->0/0, (1,1,0)->0/0, (1,1,1)->1/1.
REQ-033 Start pulses during RUN with different operands -> ignored; the first operation's result is delivered unchanged, and the old diff is held until EN.
REQ-034 rst pulse at slice 4 of an 8-slice run -> all outputs 0 immediately, no done pulse; a following start completes normally with a correct result.
